// File: rtl/mips32_prefetch_queue.sv
// MIPS32 fetch front end: owns the PC, fetches one word at a time into a DEPTH-entry FIFO popped by ID; ack in cycle N -> id_valid in N+1.
// Requests issue only when a slot is guaranteed; MIPS32_PREFETCH_HLT_STOP_EN stops issue after a pushed HLT until redirect/reset.
module mips32_prefetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  input  logic                    stall,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [31:0]             id_ir,
  output logic [ADDR_W-1:0]       id_npc,
  output logic [$clog2(DEPTH):0]  q_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SQUASH = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, pop_req, slot_ok, hlt_block;
  logic [31:0]       ir_mem  [DEPTH];
  logic [ADDR_W-1:0] npc_mem [DEPTH];

`ifdef MIPS32_PREFETCH_HLT_STOP_EN
  logic hlt_q, hlt_d;
  assign hlt_block = hlt_q;
`else
  assign hlt_block = 1'b0;
`endif

  assign pop_req = id_valid && id_ready;
  // Conservative slot test: a pop in the issue cycle is not credited until it has happened.
  assign slot_ok = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, pop_req}) < (CNT_W + 1)'(DEPTH);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push     = 1'b0;
    pop      = pop_req && !redirect_valid;
`ifdef MIPS32_PREFETCH_HLT_STOP_EN
    hlt_d    = hlt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!redirect_valid && !stall && !hlt_block && slot_ok) begin
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = SQUASH;
        end
      end
      SQUASH: begin
        // The abandoned request still has to complete before a new one may start.
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      pc_d     = pc_q + ADDR_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
`ifdef MIPS32_PREFETCH_HLT_STOP_EN
      if (imem_rdata[31:26] == 6'b111111) hlt_d = 1'b1;
`endif
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
`ifdef MIPS32_PREFETCH_HLT_STOP_EN
      hlt_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef MIPS32_PREFETCH_HLT_STOP_EN
  always_ff @(posedge clk1) begin
    if (!rst_n) hlt_q <= 1'b0;
    else        hlt_q <= hlt_d;
  end
`endif

  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_ptr_q]  <= imem_rdata;
      npc_mem[wr_ptr_q] <= pc_q + ADDR_W'(1);
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign id_valid  = (cnt_q != '0);
  assign id_ir     = ir_mem[rd_ptr_q];
  assign id_npc    = npc_mem[rd_ptr_q];
  assign q_count   = cnt_q;

endmodule
